// File: rtl/bus_proto_pkg.sv
// Shared definitions for data-bus responders: state encoding, bus width and RW encoding.
package bus_proto_pkg;

    localparam int unsigned BUS_WIDTH = 16;

    // Bus responder handshake states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        TURN  = 2'd2
    } bus_state_t;

    // RW line encoding
    localparam logic READ  = 1'b1;
    localparam logic WRITE = 1'b0;

endpackage : bus_proto_pkg

// File: rtl/bus_turn_fsm.sv
// Read/turnaround sequencer shared by bus responders: tracks DRIVE/TURN, gates writes.
module bus_turn_fsm
    import bus_proto_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_rw,
    input  logic       i_enable,
    output bus_state_t o_state,
    output logic       o_busy,
    output logic       o_data_oe,
    output logic       o_wr_accept_c
);

    bus_state_t r_state;
    bus_state_t w_state_nxt;
    logic       w_rd;
    logic       w_wr;

    assign w_rd = i_enable & (i_rw == READ);
    assign w_wr = i_enable & (i_rw == WRITE);

    // State register with synchronous reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: any read goes (or stays) in DRIVE, a dropped read passes through TURN
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    w_state_nxt = w_rd ? DRIVE : IDLE;
            DRIVE:   w_state_nxt = w_rd ? DRIVE : TURN;
            TURN:    w_state_nxt = w_rd ? DRIVE : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from the registered state; writes only accepted in IDLE
    always_comb begin
        o_busy        = 1'b0;
        o_data_oe     = 1'b0;
        o_wr_accept_c = 1'b0;
        case (r_state)
            IDLE:    o_wr_accept_c = w_wr;
            DRIVE: begin
                o_busy    = 1'b1;
                o_data_oe = 1'b1;
            end
            TURN:    o_busy = 1'b1;
            default: ;
        endcase
    end

    assign o_state = r_state;

endmodule : bus_turn_fsm

// File: rtl/bus_count_reg.sv
// Loadable incrementing bus register with registered read data and sticky wrap flag.
module bus_count_reg
    import bus_proto_pkg::*;
#(
    parameter int unsigned       WIDTH       = BUS_WIDTH,
    parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic             RW,
    input  logic             ENABLE,
    input  logic             COUNT,
    input  logic [WIDTH-1:0] DATA_IN,
    output logic [WIDTH-1:0] DATA_OUT,
    output logic             DATA_OE,
    output logic             BUSY,
    output logic             CARRY
);

    bus_state_t       w_state;
    logic             w_wr_accept;
    logic             w_load;
    logic             w_rd;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_data_out;
    logic             r_carry;

    bus_turn_fsm u_fsm (
        .i_clk         (CLOCK),
        .i_rst         (RESET),
        .i_rw          (RW),
        .i_enable      (ENABLE),
        .o_state       (w_state),
        .o_busy        (BUSY),
        .o_data_oe     (DATA_OE),
        .o_wr_accept_c (w_wr_accept)
    );

    assign w_rd   = ENABLE & (RW == READ);
    assign w_load = w_wr_accept & (w_state == IDLE);

    // Counter and carry: accepted write beats COUNT; wrap from all-ones sets sticky carry
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_count <= RESET_VALUE;
            r_carry <= 1'b0;
        end else if (w_load) begin
            r_count <= DATA_IN;
            r_carry <= 1'b0;
        end else if (COUNT) begin
            r_count <= r_count + WIDTH'(1);
            if (&r_count) begin
                r_carry <= 1'b1;
            end
        end
    end

    // Read data captures the pre-increment register value on every sampled read
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_data_out <= '0;
        end else if (w_rd) begin
            r_data_out <= r_count;
        end
    end

    assign DATA_OUT = r_data_out;
    assign CARRY    = r_carry;

endmodule : bus_count_reg

// File: tb/tb_bus_count_reg.sv
// Directed bench for bus_count_reg: reset, writes, read bursts, wrap, turnaround, reset mid-read.
module tb_bus_count_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        rw;
    logic        en;
    logic        cnt;
    logic [15:0] din;
    logic [15:0] dout;
    logic        oe;
    logic        busy;
    logic        carry;

    int checks   = 0;
    int failures = 0;

    bus_count_reg #(.WIDTH(16), .RESET_VALUE(16'h0000)) dut (
        .CLOCK    (clk),
        .RESET    (rst),
        .RW       (rw),
        .ENABLE   (en),
        .COUNT    (cnt),
        .DATA_IN  (din),
        .DATA_OUT (dout),
        .DATA_OE  (oe),
        .BUSY     (busy),
        .CARRY    (carry)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Apply inputs, clock one edge, settle past it
    task automatic step(input logic r, input logic e, input logic w_rw, input logic c, input logic [15:0] d);
        rst = r; en = e; rw = w_rw; cnt = c; din = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [15:0] d);
        step(1'b0, 1'b1, 1'b0, 1'b0, d);
    endtask

    // Single read then turnaround back to IDLE
    task automatic do_read(input string tag, input logic [15:0] exp);
        step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
        chk({tag, "_oe"}, 32'(oe), 32'd1);
        chk({tag, "_data"}, 32'(dout), 32'(exp));
        step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; rw = 1'b0; cnt = 1'b0; din = '0;
        @(negedge clk);

        // Reset for two cycles
        step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
        chk("rst_oe", 32'(oe), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_carry", 32'(carry), 32'd0);
        chk("rst_dout", 32'(dout), 32'd0);
        do_read("rst_val", 16'h0000);

        // Write then read back
        do_write(16'hA5A5);
        chk("wr_busy", 32'(busy), 32'd0);
        chk("wr_carry", 32'(carry), 32'd0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
        chk("rd1_oe", 32'(oe), 32'd1);
        chk("rd1_busy", 32'(busy), 32'd1);
        chk("rd1_data", 32'(dout), 32'h0000A5A5);
        step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
        chk("turn1_oe", 32'(oe), 32'd0);
        chk("turn1_busy", 32'(busy), 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
        chk("idle1_busy", 32'(busy), 32'd0);

        // Read burst with COUNT held
        do_write(16'h0010);
        step(1'b0, 1'b1, 1'b1, 1'b1, 16'h0);
        chk("burst0", 32'(dout), 32'h10);
        step(1'b0, 1'b1, 1'b1, 1'b1, 16'h0);
        chk("burst1", 32'(dout), 32'h11);
        step(1'b0, 1'b1, 1'b1, 1'b1, 16'h0);
        chk("burst2", 32'(dout), 32'h12);
        chk("burst_oe", 32'(oe), 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
        chk("burst_turn_oe", 32'(oe), 32'd0);
        chk("burst_turn_busy", 32'(busy), 32'd1);
        // Read in TURN re-enters DRIVE without a gap
        step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
        chk("reenter_oe", 32'(oe), 32'd1);
        chk("reenter_data", 32'(dout), 32'h13);
        step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
        chk("burst_idle_busy", 32'(busy), 32'd0);

        // Wrap sets sticky carry, write clears it
        do_write(16'hFFFF);
        step(1'b0, 1'b0, 1'b0, 1'b1, 16'h0);
        chk("wrap_carry", 32'(carry), 32'd1);
        do_read("wrap_val", 16'h0000);
        step(1'b0, 1'b0, 1'b0, 1'b1, 16'h0);
        chk("wrap_sticky", 32'(carry), 32'd1);
        do_read("wrap_val2", 16'h0001);
        do_write(16'h0001);
        chk("wrap_clear", 32'(carry), 32'd0);

        // Write in TURN ignored
        do_write(16'h5555);
        step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 16'h1234);
        step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
        do_read("turn_block", 16'h5555);
        // Write in DRIVE ignored, held write after TURN accepted
        step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 16'h1234);
        step(1'b0, 1'b1, 1'b0, 1'b0, 16'h1234);
        chk("turn_hold_busy", 32'(busy), 32'd0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 16'h1234);
        do_read("turn_hold", 16'h1234);

        // Write beats COUNT
        step(1'b0, 1'b1, 1'b0, 1'b1, 16'h0005);
        do_read("wr_cnt", 16'h0005);
        do_write(16'hFFFF);
        step(1'b0, 1'b1, 1'b0, 1'b1, 16'h0000);
        chk("wr_wrap_carry", 32'(carry), 32'd0);
        do_read("wr_wrap_val", 16'h0000);

        // Reset during DRIVE
        do_write(16'hFFFF);
        step(1'b0, 1'b0, 1'b0, 1'b1, 16'h0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 16'h0);
        chk("pre_rst_carry", 32'(carry), 32'd1);
        step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
        chk("pre_rst_data", 32'(dout), 32'h1);
        step(1'b1, 1'b1, 1'b1, 1'b1, 16'h0);
        chk("midrst_oe", 32'(oe), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_carry", 32'(carry), 32'd0);
        chk("midrst_dout", 32'(dout), 32'd0);
        do_read("midrst_val", 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_bus_count_reg
